// File: rtl/nn_noc_endpoint.sv
// nn_noc_endpoint: credit-flow-controlled NoC endpoint between an NN layer and
// a CONNECT send/recv port pair. TX splits a layer vector into a multi-flit
// packet gated by per-VC credits; RX buffers flits, reassembles the vector and
// returns one credit per flit consumed.
module nn_noc_endpoint #(
  parameter int FLIT_DATA_WIDTH = 64,
  parameter int DEST_BITS       = 2,
  parameter int VC_BITS         = 1,
  parameter int NUM_VCS         = 2,
  parameter int CREDITS_PER_VC  = 2,
  parameter int VEC_WIDTH       = 126,
  parameter int RX_DEPTH        = 4,
  localparam int P              = FLIT_DATA_WIDTH - 1,
  localparam int FLIT_W         = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [VEC_WIDTH-1:0] tx_vec,
  input  logic [DEST_BITS-1:0] tx_dest,
  input  logic [VC_BITS-1:0]   tx_vc,
  input  logic                 tx_mode,
  output logic [FLIT_W-1:0]    flit_out,
  output logic                 flit_out_en,
  input  logic [VC_BITS:0]     credit_in,
  input  logic [FLIT_W-1:0]    flit_in,
  output logic [VC_BITS:0]     credit_out,
  output logic                 credit_out_en,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [VEC_WIDTH-1:0] rx_vec,
  output logic                 rx_mode,
  output logic [VC_BITS-1:0]   rx_vc,
  output logic [2:0]           err
);
  localparam int NUM_FLITS = (VEC_WIDTH + P - 1) / P;
  localparam int PAD_W     = NUM_FLITS * P;
  localparam int TXI_W     = $clog2(NUM_FLITS + 1);
  localparam int IDX_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam int CRED_W    = $clog2(CREDITS_PER_VC + 1);
  localparam int PTR_W     = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int CNT_W     = $clog2(RX_DEPTH + 1);

  typedef enum logic [0:0] {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_e;

  tx_state_e           tx_state_q;
  logic                tx_ready_q;
  logic [PAD_W-1:0]    tx_vec_q;
  logic [DEST_BITS-1:0] tx_dest_q;
  logic [VC_BITS-1:0]  tx_vc_q;
  logic                tx_mode_q;
  logic [TXI_W-1:0]    tx_idx_q;
  logic [FLIT_W-1:0]   flit_out_q;
  logic [CRED_W-1:0]   credit_q [NUM_VCS];
  logic [2:0]          err_q;

  logic [PAD_W-1:0]    snd_vec_s;
  logic [DEST_BITS-1:0] snd_dest_s;
  logic [VC_BITS-1:0]  snd_vc_s;
  logic                snd_mode_s;
  logic [TXI_W-1:0]    snd_idx_s;
  logic                snd_pending_s;
  logic                snd_avail_s;
  logic                snd_fire_s;
  logic [FLIT_W-1:0]   snd_flit_s;
  logic                cin_valid_s;
  logic [VC_BITS-1:0]  cin_vc_s;
  logic [NUM_VCS-1:0]  cr_inc_s;
  logic [NUM_VCS-1:0]  cr_dec_s;
  logic [NUM_VCS-1:0]  cr_ovf_s;

  logic [FLIT_W-1:0]   rxf_mem_q [RX_DEPTH];
  logic [PTR_W-1:0]    rxf_rd_q;
  logic [PTR_W-1:0]    rxf_wr_q;
  logic [CNT_W-1:0]    rxf_cnt_q;
  logic [PAD_W-1:0]    rx_buf_q;
  logic [IDX_W-1:0]    rx_idx_q;
  logic                rx_valid_q;
  logic                rx_mode_q;
  logic [VC_BITS-1:0]  rx_vc_q;

  logic [FLIT_W-1:0]   head_s;
  logic                head_tail_s;
  logic [VC_BITS-1:0]  head_vc_s;
  logic                head_mode_s;
  logic [P-1:0]        head_pay_s;
  logic                pop_s;
  logic                push_s;
  logic                rx_ovf_s;
  logic                rx_last_s;
  logic                rx_frm_s;
  logic                unused_ok_s;

  assign cin_valid_s = credit_in[VC_BITS];
  assign cin_vc_s    = credit_in[VC_BITS-1:0];

  // Select the flit candidate: straight from the inputs on the accepting cycle, else from the latched packet
  always_comb begin
    snd_vec_s     = tx_vec_q;
    snd_dest_s    = tx_dest_q;
    snd_vc_s      = tx_vc_q;
    snd_mode_s    = tx_mode_q;
    snd_idx_s     = tx_idx_q;
    snd_pending_s = 1'b0;
    if (tx_state_q == TX_IDLE) begin
      snd_vec_s     = PAD_W'(tx_vec);
      snd_dest_s    = tx_dest;
      snd_vc_s      = tx_vc;
      snd_mode_s    = tx_mode;
      snd_idx_s     = '0;
      snd_pending_s = tx_valid;
    end else begin
      snd_pending_s = (tx_idx_q < TXI_W'(NUM_FLITS));
    end
    // A credit returned this cycle already counts for the flit registered at this edge
    snd_avail_s = (credit_q[snd_vc_s] != '0) || (cin_valid_s && (cin_vc_s == snd_vc_s));
    snd_fire_s  = snd_pending_s && snd_avail_s;
    snd_flit_s  = {1'b1, (snd_idx_s == TXI_W'(NUM_FLITS - 1)), snd_dest_s, snd_vc_s,
                   snd_mode_s, snd_vec_s[snd_idx_s*P +: P]};
  end

  // Per-VC credit increment/decrement/overflow events
  always_comb begin
    cr_inc_s = '0;
    cr_dec_s = '0;
    cr_ovf_s = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      cr_inc_s[v] = cin_valid_s && (cin_vc_s == VC_BITS'(v));
      cr_dec_s[v] = snd_fire_s && (snd_vc_s == VC_BITS'(v));
      cr_ovf_s[v] = cr_inc_s[v] && !cr_dec_s[v] && (credit_q[v] == CRED_W'(CREDITS_PER_VC));
    end
  end

  // TX packet FSM with registered flit output
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_ready_q <= 1'b1;
      tx_vec_q   <= '0;
      tx_dest_q  <= '0;
      tx_vc_q    <= '0;
      tx_mode_q  <= 1'b0;
      tx_idx_q   <= '0;
      flit_out_q <= '0;
    end else begin
      flit_out_q <= snd_fire_s ? snd_flit_s : '0;
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_valid) begin
            tx_vec_q   <= snd_vec_s;
            tx_dest_q  <= tx_dest;
            tx_vc_q    <= tx_vc;
            tx_mode_q  <= tx_mode;
            tx_idx_q   <= snd_fire_s ? TXI_W'(1) : TXI_W'(0);
            tx_state_q <= TX_SEND;
            tx_ready_q <= 1'b0;
          end
        end
        TX_SEND: begin
          // All flits out: spend one cycle here, giving the idle gap between packets
          if (tx_idx_q == TXI_W'(NUM_FLITS)) begin
            tx_state_q <= TX_IDLE;
            tx_ready_q <= 1'b1;
          end else if (snd_fire_s) begin
            tx_idx_q <= tx_idx_q + TXI_W'(1);
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Credit counters (saturating at the router buffer depth) and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VCS; v++) credit_q[v] <= CRED_W'(CREDITS_PER_VC);
      err_q <= 3'b000;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (cr_inc_s[v] && !cr_dec_s[v] && !cr_ovf_s[v]) begin
          credit_q[v] <= credit_q[v] + CRED_W'(1);
        end else if (cr_dec_s[v] && !cr_inc_s[v]) begin
          credit_q[v] <= credit_q[v] - CRED_W'(1);
        end else begin
          credit_q[v] <= credit_q[v];
        end
      end
      err_q <= err_q | {(|cr_ovf_s), rx_frm_s, rx_ovf_s};
    end
  end

  assign head_s      = rxf_mem_q[rxf_rd_q];
  assign head_tail_s = head_s[FLIT_W-2];
  assign head_vc_s   = head_s[FLIT_DATA_WIDTH +: VC_BITS];
  assign head_mode_s = head_s[FLIT_DATA_WIDTH-1];
  assign head_pay_s  = head_s[P-1:0];
  assign pop_s       = (rxf_cnt_q != '0) && !rx_valid_q;
  assign rx_ovf_s    = flit_in[FLIT_W-1] && (rxf_cnt_q == CNT_W'(RX_DEPTH));
  assign push_s      = flit_in[FLIT_W-1] && !rx_ovf_s;
  assign rx_last_s   = (rx_idx_q == IDX_W'(NUM_FLITS - 1));
  assign rx_frm_s    = pop_s && ((head_tail_s != rx_last_s) ||
                                 ((rx_idx_q != '0) && (head_vc_s != rx_vc_q)));
  assign unused_ok_s = ^{head_s[FLIT_W-1], head_s[FLIT_W-3 -: DEST_BITS]};

  // RX FIFO storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (push_s) begin
      rxf_mem_q[rxf_wr_q] <= flit_in;
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      rxf_rd_q  <= '0;
      rxf_wr_q  <= '0;
      rxf_cnt_q <= '0;
    end else begin
      if (push_s) rxf_wr_q <= rxf_wr_q + PTR_W'(1);
      if (pop_s)  rxf_rd_q <= rxf_rd_q + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   rxf_cnt_q <= rxf_cnt_q + CNT_W'(1);
        2'b01:   rxf_cnt_q <= rxf_cnt_q - CNT_W'(1);
        default: rxf_cnt_q <= rxf_cnt_q;
      endcase
    end
  end

  // Packet reassembly; the first chunk of a packet clears the rest so short packets read back as zero
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_buf_q   <= '0;
      rx_idx_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_mode_q  <= 1'b0;
      rx_vc_q    <= '0;
    end else if (rx_valid_q) begin
      if (rx_ready) rx_valid_q <= 1'b0;
    end else if (pop_s) begin
      if (rx_idx_q == '0) begin
        rx_buf_q <= PAD_W'(head_pay_s);
      end else begin
        rx_buf_q[rx_idx_q*P +: P] <= head_pay_s;
      end
      rx_mode_q <= head_mode_s;
      rx_vc_q   <= head_vc_s;
      if (head_tail_s) begin
        rx_valid_q <= 1'b1;
        rx_idx_q   <= '0;
      end else if (!rx_last_s) begin
        rx_idx_q <= rx_idx_q + IDX_W'(1);
      end
    end
  end

  assign tx_ready      = tx_ready_q;
  assign flit_out      = flit_out_q;
  assign flit_out_en   = flit_out_q[FLIT_W-1];
  assign credit_out    = pop_s ? {1'b1, head_vc_s} : '0;
  assign credit_out_en = pop_s;
  assign rx_valid      = rx_valid_q;
  assign rx_vec        = rx_buf_q[VEC_WIDTH-1:0];
  assign rx_mode       = rx_mode_q;
  assign rx_vc         = rx_vc_q;
  assign err           = err_q;
endmodule

// File: tb/tb_nn_noc_endpoint.sv
// Testbench for nn_noc_endpoint: directed scenarios followed by random traffic,
// every cycle compared against a packet/queue-level reference model.
module tb_nn_noc_endpoint;
  localparam int FW = 69;
  localparam int NF = 2;
  localparam int PW = 63;
  localparam int RXD = 4;
  localparam int CRED = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_valid;
  logic          tx_ready;
  logic [125:0]  tx_vec;
  logic [1:0]    tx_dest;
  logic          tx_vc;
  logic          tx_mode;
  logic [FW-1:0] flit_out;
  logic          flit_out_en;
  logic [1:0]    credit_in;
  logic [FW-1:0] flit_in;
  logic [1:0]    credit_out;
  logic          credit_out_en;
  logic          rx_valid;
  logic          rx_ready;
  logic [125:0]  rx_vec;
  logic          rx_mode;
  logic          rx_vc;
  logic [2:0]    err;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  logic [FW-1:0] m_txq[$];
  bit            m_busy;
  logic          m_txvc;
  logic [FW-1:0] m_flit;
  int            m_cred[2];
  logic [2:0]    m_err;
  logic [FW-1:0] m_rxq[$];
  logic [PW-1:0] m_chunk[NF];
  int            m_ridx;
  bit            m_rvalid;
  logic          m_rmode;
  logic          m_rvc;

  nn_noc_endpoint dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_vec(tx_vec), .tx_dest(tx_dest), .tx_vc(tx_vc), .tx_mode(tx_mode),
    .flit_out(flit_out), .flit_out_en(flit_out_en), .credit_in(credit_in),
    .flit_in(flit_in), .credit_out(credit_out), .credit_out_en(credit_out_en),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_vec(rx_vec), .rx_mode(rx_mode),
    .rx_vc(rx_vc), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mkflit(input logic t, input logic [1:0] d,
                                           input logic vc, input logic m,
                                           input logic [PW-1:0] pay);
    return {1'b1, t, d, vc, m, pay};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_txq.delete();
    m_rxq.delete();
    m_busy = 0; m_txvc = 1'b0; m_flit = '0;
    m_cred[0] = CRED; m_cred[1] = CRED;
    m_err = 3'b000;
    for (int k = 0; k < NF; k++) m_chunk[k] = '0;
    m_ridx = 0; m_rvalid = 0; m_rmode = 1'b0; m_rvc = 1'b0;
  endtask

  // advance the model by one clock using the inputs currently applied
  task automatic model_step();
    bit pop;
    bit sent;
    bit inc[2];
    int pre;
    logic [FW-1:0] pf;
    if (reset) begin
      model_reset();
      return;
    end
    // receive side
    pre = m_rxq.size();
    pop = (pre > 0) && !m_rvalid;
    pf = '0;
    if (pop) pf = m_rxq.pop_front();
    if (m_rvalid && rx_ready) m_rvalid = 0;
    if (flit_in[FW-1]) begin
      if (pre == RXD) m_err[0] = 1'b1;
      else m_rxq.push_back(flit_in);
    end
    if (pop) begin
      if (m_ridx == 0) begin
        for (int k = 0; k < NF; k++) m_chunk[k] = '0;
      end else if (pf[64] != m_rvc) begin
        m_err[1] = 1'b1;
      end
      m_chunk[m_ridx] = pf[PW-1:0];
      m_rmode = pf[63];
      m_rvc = pf[64];
      if (pf[67]) begin
        if (m_ridx != NF - 1) m_err[1] = 1'b1;
        m_rvalid = 1;
        m_ridx = 0;
      end else if (m_ridx == NF - 1) begin
        m_err[1] = 1'b1;
      end else begin
        m_ridx++;
      end
    end
    // transmit side
    for (int v = 0; v < 2; v++) inc[v] = credit_in[1] && (credit_in[0] == v[0]);
    sent = 0;
    m_flit = '0;
    if (!m_busy && tx_valid) begin
      for (int k = 0; k < NF; k++)
        m_txq.push_back(mkflit(k == NF - 1, tx_dest, tx_vc, tx_mode, tx_vec[k*PW +: PW]));
      m_txvc = tx_vc;
      m_busy = 1;
    end else if (m_busy && m_txq.size() == 0) begin
      m_busy = 0;
    end
    if (m_busy && m_txq.size() > 0 && (m_cred[m_txvc] > 0 || inc[m_txvc])) begin
      m_flit = m_txq.pop_front();
      sent = 1;
    end
    for (int v = 0; v < 2; v++) begin
      bit dec;
      dec = sent && (m_txvc == v[0]);
      if (inc[v] && !dec) begin
        if (m_cred[v] == CRED) m_err[2] = 1'b1;
        else m_cred[v]++;
      end else if (dec && !inc[v]) begin
        m_cred[v]--;
      end
    end
  endtask

  task automatic check_all();
    logic [125:0] ev;
    logic [1:0] ec;
    for (int k = 0; k < NF; k++) ev[k*PW +: PW] = m_chunk[k];
    ec = (m_rxq.size() > 0 && !m_rvalid) ? {1'b1, m_rxq[0][64]} : 2'b00;
    chk("tx_ready", tx_ready, !m_busy);
    chk("flit_out", flit_out, m_flit);
    chk("flit_out_en", flit_out_en, m_flit[FW-1]);
    chk("credit_out", credit_out, ec);
    chk("credit_out_en", credit_out_en, ec[1]);
    chk("rx_valid", rx_valid, m_rvalid);
    chk("rx_vec", rx_vec, ev);
    chk("rx_mode", rx_mode, m_rmode);
    chk("rx_vc", rx_vc, m_rvc);
    chk("err", err, m_err);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [127:0] r;
    reset = 1'b1; tx_valid = 1'b0; tx_vec = '0; tx_dest = 2'd0; tx_vc = 1'b0;
    tx_mode = 1'b0; credit_in = 2'b00; flit_in = '0; rx_ready = 1'b0;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    chk("reset_tx_ready", tx_ready, 1'b1);
    chk("reset_flit_out", flit_out, '0);
    chk("reset_err", err, 3'b000);

    // basic two-flit packet
    tx_valid = 1'b1; tx_vec = {63'h1, 63'h2}; tx_dest = 2'd2; tx_vc = 1'b0; tx_mode = 1'b0;
    tick();
    tx_valid = 1'b0;
    chk("pkt_flit0", flit_out, mkflit(1'b0, 2'd2, 1'b0, 1'b0, 63'h2));
    tick();
    chk("pkt_flit1", flit_out, mkflit(1'b1, 2'd2, 1'b0, 1'b0, 63'h1));
    chk("pkt_busy", tx_ready, 1'b0);
    tick();
    chk("pkt_ready_back", tx_ready, 1'b1);

    // refill vc0, then two packets: the second stalls on credits
    credit_in = 2'b10; tick(); tick();
    credit_in = 2'b00;
    tx_valid = 1'b1; tx_vec = {63'h5, 63'h6}; tx_dest = 2'd3; tick();
    tx_valid = 1'b0; tick(); tick();
    chk("stall_ready", tx_ready, 1'b1);
    tx_valid = 1'b1; tx_vec = {63'h3, 63'h4}; tx_dest = 2'd1; tick();
    tx_valid = 1'b0;
    chk("stall_no_flit", flit_out_en, 1'b0);
    tick(); tick();
    chk("stall_hold", flit_out, '0);
    credit_in = 2'b10; tick();
    credit_in = 2'b00;
    chk("credit_flit", flit_out, mkflit(1'b0, 2'd1, 1'b0, 1'b0, 63'h4));
    tick();
    chk("credit_one_only", flit_out_en, 1'b0);
    credit_in = 2'b10; tick();
    credit_in = 2'b00;
    chk("credit_tail", flit_out, mkflit(1'b1, 2'd1, 1'b0, 1'b0, 63'h3));
    tick(); tick();
    credit_in = 2'b10; tick(); tick();
    credit_in = 2'b00;

    // credit overflow on a full vc1
    credit_in = 2'b11; tick();
    credit_in = 2'b00;
    chk("credit_ovf", err[2], 1'b1);

    // two-flit receive with rx_ready low
    flit_in = mkflit(1'b0, 2'd1, 1'b1, 1'b1, 63'hA); tick();
    chk("rx_credit0", credit_out, 2'b11);
    flit_in = mkflit(1'b1, 2'd1, 1'b1, 1'b1, 63'hB); tick();
    chk("rx_credit1", credit_out, 2'b11);
    flit_in = '0; tick();
    chk("rx_vec", rx_vec, {63'hB, 63'hA});
    chk("rx_mode_vc", {rx_valid, rx_mode, rx_vc}, 3'b111);
    tick(); tick();
    chk("rx_held", rx_valid, 1'b1);

    // five flits while the vector is held: four buffered, fifth overflows
    for (int k = 0; k < 5; k++) begin
      flit_in = mkflit(k[0], 2'd0, 1'b0, 1'b0, 63'(k + 16));
      tick();
      chk("rx_no_credit", credit_out_en, 1'b0);
    end
    flit_in = '0;
    chk("rx_ovf", err[0], 1'b1);
    rx_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    rx_ready = 1'b0;

    // reset in the middle of a packet
    tx_valid = 1'b1; tx_vec = {63'h7, 63'h8}; tx_vc = 1'b1; tick();
    tx_valid = 1'b0;
    chk("midrst_flit0", flit_out_en, 1'b1);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("midrst_flit", flit_out, '0);
    chk("midrst_ready", tx_ready, 1'b1);
    chk("midrst_err", err, 3'b000);
    tx_valid = 1'b1; tx_vec = {63'h9, 63'hC}; tx_vc = 1'b1; tick();
    tx_valid = 1'b0;
    chk("midrst_cred0", flit_out_en, 1'b1);
    tick();
    chk("midrst_cred1", flit_out_en, 1'b1);
    tick();

    // short packet: tail on the first chunk
    flit_in = mkflit(1'b1, 2'd0, 1'b0, 1'b0, 63'hC); tick();
    flit_in = '0; tick(); tick();
    chk("short_vec", rx_vec, 126'hC);
    chk("short_frm", err[1], 1'b1);
    rx_ready = 1'b1; tick(); tick();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      tx_valid = ($urandom_range(0, 2) == 0);
      tx_vec = r[125:0];
      tx_dest = 2'($urandom_range(0, 3));
      tx_vc = 1'($urandom_range(0, 1));
      tx_mode = 1'($urandom_range(0, 1));
      credit_in = {($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1))};
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      flit_in = ($urandom_range(0, 1) == 0) ? {1'b1, r[67:0]} : '0;
      rx_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
